// File: rtl/key_pkg.sv
// Shared definitions for the PS/2 key-to-note path.
// Holds the scan codes with special meaning, the "no key" index value and
// the prefix-tracking FSM state encodings.
package key_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_e;

endpackage

// File: rtl/key_note_map.sv
// Combinational scan code -> piano key index map (13-key layout).
// Ports:
//   code    - 8-bit scan code
//   key_idx - key index 0..12, or KEY_NONE for anything unmapped
//             (octave keys are also KEY_NONE here; they are handled upstream)
module key_note_map
    import key_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] key_idx
);

    always_comb begin
        key_idx = KEY_NONE;
        case (code)
            8'h1C:   key_idx = 4'd0;
            8'h1D:   key_idx = 4'd1;
            8'h1B:   key_idx = 4'd2;
            8'h24:   key_idx = 4'd3;
            8'h23:   key_idx = 4'd4;
            8'h2B:   key_idx = 4'd5;
            8'h2C:   key_idx = 4'd6;
            8'h34:   key_idx = 4'd7;
            8'h35:   key_idx = 4'd8;
            8'h33:   key_idx = 4'd9;
            8'h3C:   key_idx = 4'd10;
            8'h3B:   key_idx = 4'd11;
            8'h42:   key_idx = 4'd12;
            default: key_idx = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/key_note_decoder.sv
// Monophonic last-key-priority note decoder behind a PS/2 receiver.
// Tracks F0 (break) / E0 (extended) prefixes, maps 13 keys to a note number
// and handles two saturating octave-shift keys.
// Ports:
//   clk_50Mhz - system clock
//   rst       - asynchronous active-high reset
//   code      - scan code, stable while idle is high
//   idle      - receiver idle flag (async); rising edge = new code
//   note      - octave*12 + key index (0..60)
//   gate      - high while the current note's key is held
//   note_stb  - one-cycle pulse when note is loaded by a key make
//   octave    - current octave 0..OCT_MAX
module key_note_decoder
    import key_pkg::*;
#(
    parameter int OCT_RESET = 2,
    parameter int OCT_MAX   = 4
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       idle,
    output logic [5:0] note,
    output logic       gate,
    output logic       note_stb,
    output logic [2:0] octave
);

    localparam logic [2:0] OCT_RST_V = 3'(OCT_RESET);
    localparam logic [2:0] OCT_MAX_V = 3'(OCT_MAX);

    // [0],[1] synchronise idle; [2] is the edge-detect delay.
    logic [2:0] sync_q, sync_d;
    logic       code_stb;

    state_e     state_q, state_d;
    logic [5:0] note_q, note_d;
    logic       gate_q, gate_d;
    logic       note_stb_q, note_stb_d;
    logic [2:0] oct_q, oct_d;
    logic [3:0] held_q, held_d;

    logic [3:0] key_idx;
    logic [5:0] oct12;
    logic       make_ev, brk_ev;

    key_note_map u_map (
        .code    (code),
        .key_idx (key_idx)
    );

    assign code_stb = sync_q[1] & ~sync_q[2];
    assign oct12    = {oct_q, 3'b000} + {1'b0, oct_q, 2'b00};

    always_comb begin
        sync_d     = {sync_q[1:0], idle};
        state_d    = state_q;
        note_d     = note_q;
        gate_d     = gate_q;
        held_d     = held_q;
        oct_d      = oct_q;
        note_stb_d = 1'b0;
        make_ev    = 1'b0;
        brk_ev     = 1'b0;

        if (code_stb) begin
            case (state_q)
                S_IDLE: begin
                    if (code == SC_EXT)        state_d = S_EXT;
                    else if (code == SC_BREAK) state_d = S_BRK;
                    else                       make_ev = 1'b1;
                end
                S_BRK: begin
                    if (code == SC_BREAK)    state_d = S_BRK;
                    else if (code == SC_EXT) state_d = S_EXT_BRK;
                    else begin
                        brk_ev  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    // Extended keys are not part of the layout; drop them.
                    if (code == SC_BREAK) state_d = S_EXT_BRK;
                    else                  state_d = S_IDLE;
                end
                S_EXT_BRK: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end

        if (make_ev) begin
            if (key_idx != KEY_NONE) begin
                // A repeat of the held key (typematic) must not retrigger.
                if (!(gate_q && key_idx == held_q)) begin
                    note_d     = oct12 + {2'b00, key_idx};
                    held_d     = key_idx;
                    gate_d     = 1'b1;
                    note_stb_d = 1'b1;
                end
            end else if (code == SC_OCT_DN) begin
                if (oct_q != 3'd0) oct_d = oct_q - 3'd1;
            end else if (code == SC_OCT_UP) begin
                if (oct_q < OCT_MAX_V) oct_d = oct_q + 3'd1;
            end
        end

        // Only releasing the most recent key closes the gate.
        if (brk_ev && key_idx != KEY_NONE && gate_q && key_idx == held_q)
            gate_d = 1'b0;
    end

    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            sync_q     <= 3'b111;
            state_q    <= S_IDLE;
            note_q     <= 6'd0;
            gate_q     <= 1'b0;
            note_stb_q <= 1'b0;
            oct_q      <= OCT_RST_V;
            held_q     <= KEY_NONE;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            note_q     <= note_d;
            gate_q     <= gate_d;
            note_stb_q <= note_stb_d;
            oct_q      <= oct_d;
            held_q     <= held_d;
        end
    end

    assign note     = note_q;
    assign gate     = gate_q;
    assign note_stb = note_stb_q;
    assign octave   = oct_q;

endmodule

// File: tb/tb_key_note_decoder.sv
// Self-checking bench for key_note_decoder. Each scan code sent pushes the
// expected post-code outputs onto a scoreboard; they are popped and compared
// once the DUT has had time to register the code.
module tb_key_note_decoder;

    logic       clk_50Mhz = 1'b0;
    logic       rst;
    logic [7:0] code;
    logic       idle;
    logic [5:0] note;
    logic       gate;
    logic       note_stb;
    logic [2:0] octave;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0] note;
        logic       gate;
        logic [2:0] oct;
        int         stb;
    } exp_t;

    exp_t sb[$];

    always #10 clk_50Mhz = ~clk_50Mhz;

    key_note_decoder #(.OCT_RESET(2), .OCT_MAX(4)) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .code      (code),
        .idle      (idle),
        .note      (note),
        .gate      (gate),
        .note_stb  (note_stb),
        .octave    (octave)
    );

    task automatic apply_reset();
        idle = 1'b1;
        code = 8'h00;
        rst  = 1'b1;
        repeat (2) @(posedge clk_50Mhz);
        @(negedge clk_50Mhz);
        rst = 1'b0;
        repeat (2) @(negedge clk_50Mhz);
    endtask

    // One PS/2 byte: idle low while "receiving", then rising edge with code.
    task automatic send(input logic [7:0] c, input logic [5:0] en, input logic eg,
                        input logic [2:0] eo, input int es, input string name);
        exp_t e;
        int   cnt;
        e.note = en; e.gate = eg; e.oct = eo; e.stb = es;
        sb.push_back(e);
        @(negedge clk_50Mhz);
        idle = 1'b0;
        code = c;
        repeat (4) @(negedge clk_50Mhz);
        idle = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50Mhz);
            if (note_stb === 1'b1) cnt++;
        end
        e = sb.pop_front();
        n_checks++;
        if (note !== e.note) $display("FAIL %s note: got %0d want %0d", name, note, e.note);
        else n_pass++;
        n_checks++;
        if (gate !== e.gate) $display("FAIL %s gate: got %b want %b", name, gate, e.gate);
        else n_pass++;
        n_checks++;
        if (octave !== e.oct) $display("FAIL %s octave: got %0d want %0d", name, octave, e.oct);
        else n_pass++;
        n_checks++;
        if (cnt != e.stb) $display("FAIL %s note_stb pulses: got %0d want %0d", name, cnt, e.stb);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({note, gate, note_stb, octave} !== {6'd0, 1'b0, 1'b0, 3'd2})
            $display("FAIL reset_values: got note=%0d gate=%b stb=%b oct=%0d want 0 0 0 2",
                     note, gate, note_stb, octave);
        else n_pass++;
        // Exact latency: strobe appears after the 3rd edge following idle rising.
        @(negedge clk_50Mhz);
        idle = 1'b0;
        code = 8'h1C;
        repeat (4) @(negedge clk_50Mhz);
        idle = 1'b1;
        repeat (2) @(posedge clk_50Mhz);
        #1;
        n_checks++;
        if (note_stb !== 1'b0) $display("FAIL latency_edge2 note_stb: got %b want 0", note_stb);
        else n_pass++;
        @(posedge clk_50Mhz);
        #1;
        n_checks++;
        if ({note_stb, gate, note} !== {1'b1, 1'b1, 6'd24})
            $display("FAIL latency_edge3: got stb=%b gate=%b note=%0d want 1 1 24",
                     note_stb, gate, note);
        else n_pass++;
        @(posedge clk_50Mhz);
        #1;
        n_checks++;
        if (note_stb !== 1'b0) $display("FAIL latency_edge4 note_stb: got %b want 0", note_stb);
        else n_pass++;
    endtask

    task automatic test_typematic();
        apply_reset();
        send(8'h1C, 6'd24, 1'b1, 3'd2, 1, "typ_first");
        send(8'h1C, 6'd24, 1'b1, 3'd2, 0, "typ_rep1");
        send(8'h1C, 6'd24, 1'b1, 3'd2, 0, "typ_rep2");
    endtask

    task automatic test_legato_break();
        apply_reset();
        send(8'h1C, 6'd24, 1'b1, 3'd2, 1, "leg_1C");
        send(8'h23, 6'd28, 1'b1, 3'd2, 1, "leg_23");
        send(8'hF0, 6'd28, 1'b1, 3'd2, 0, "leg_F0a");
        send(8'h1C, 6'd28, 1'b1, 3'd2, 0, "leg_brk_1C");
        send(8'hF0, 6'd28, 1'b1, 3'd2, 0, "leg_F0b");
        send(8'h23, 6'd28, 1'b0, 3'd2, 0, "leg_brk_23");
    endtask

    task automatic test_octave();
        apply_reset();
        send(8'h22, 6'd0,  1'b0, 3'd3, 0, "oct_up1");
        send(8'h22, 6'd0,  1'b0, 3'd4, 0, "oct_up2");
        send(8'h22, 6'd0,  1'b0, 3'd4, 0, "oct_up_sat");
        send(8'h42, 6'd60, 1'b1, 3'd4, 1, "oct_note60");
        send(8'h1A, 6'd60, 1'b1, 3'd3, 0, "oct_dn1");
        send(8'h1A, 6'd60, 1'b1, 3'd2, 0, "oct_dn2");
        send(8'h1A, 6'd60, 1'b1, 3'd1, 0, "oct_dn3");
        send(8'h1A, 6'd60, 1'b1, 3'd0, 0, "oct_dn4");
        send(8'h1A, 6'd60, 1'b1, 3'd0, 0, "oct_dn_sat");
        send(8'h1B, 6'd2,  1'b1, 3'd0, 1, "oct_note2");
    endtask

    task automatic test_extended();
        apply_reset();
        send(8'hE0, 6'd0,  1'b0, 3'd2, 0, "ext_E0");
        send(8'h1C, 6'd0,  1'b0, 3'd2, 0, "ext_1C");
        send(8'hE0, 6'd0,  1'b0, 3'd2, 0, "extb_E0");
        send(8'hF0, 6'd0,  1'b0, 3'd2, 0, "extb_F0");
        send(8'h1C, 6'd0,  1'b0, 3'd2, 0, "extb_1C");
        send(8'h55, 6'd0,  1'b0, 3'd2, 0, "unmapped");
        send(8'h1D, 6'd25, 1'b1, 3'd2, 1, "ext_after_1D");
    endtask

    task automatic test_reset_mid_seq();
        apply_reset();
        send(8'h1C, 6'd24, 1'b1, 3'd2, 1, "rmid_1C");
        send(8'hF0, 6'd24, 1'b1, 3'd2, 0, "rmid_F0");
        @(posedge clk_50Mhz);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({note, gate, note_stb, octave} !== {6'd0, 1'b0, 1'b0, 3'd2})
            $display("FAIL rmid_async_reset: got note=%0d gate=%b stb=%b oct=%0d want 0 0 0 2",
                     note, gate, note_stb, octave);
        else n_pass++;
        @(negedge clk_50Mhz);
        @(negedge clk_50Mhz);
        rst = 1'b0;
        send(8'h1C, 6'd24, 1'b1, 3'd2, 1, "rmid_after_1C");
    endtask

    initial begin
        rst  = 1'b1;
        idle = 1'b1;
        code = 8'h00;
        test_reset();
        test_typematic();
        test_legato_break();
        test_octave();
        test_extended();
        test_reset_mid_seq();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
